// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared op codes, FSM states and op-class predicates for ula_seq
// Purpose: single source for the 5-bit op encoding and the signedness rules
//          used by both the sequencer and the iterative mul/div datapath.
// Contents: OP_* localparams, state_t enum, is_muldiv/is_div/is_signed_a/is_signed_b.
package ula_pkg;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 0x10..0x17: the whole M group
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  // 0x14..0x17: DIV, DIVU, REM, REMU
  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// rtl/ula_muldiv_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider
// Purpose: runs XLEN iterations on operand magnitudes and applies the sign fix-up.
// Ports: clk, rst_n (async active-low); i_start loads i_op/i_a/i_b and clears the
//        counter; o_done is high in the cycle of the last iteration, with o_result
//        carrying the final (sign-corrected) value that iteration produces.
module ula_muldiv_iter
  import ula_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN - 1);

  logic              r_run;
  logic [SHW:0]      r_cnt;
  logic [4:0]        r_op;
  logic              r_neg_m;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [2*XLEN-1:0] r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;

  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [2*XLEN-1:0] w_prod_nxt;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic              w_last;

  assign w_sa    = is_signed_a(i_op) & i_a[XLEN-1];
  assign w_sb    = is_signed_b(i_op) & i_b[XLEN-1];
  assign w_mag_a = w_sa ? -i_a : i_a;
  assign w_mag_b = w_sb ? -i_b : i_b;

  // Both datapaths step every cycle; only the one selected by r_op is used.
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_rem_nxt  = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nxt  = {r_quo[XLEN-2:0], ~w_diff[XLEN]};

  // Result is taken from the next-state values so the sequencer can leave
  // CALC on the same edge that completes the final iteration.
  assign w_prod_fix = r_neg_m ? -w_prod_nxt : w_prod_nxt;
  assign w_quo_fix  = r_neg_q ? -w_quo_nxt  : w_quo_nxt;
  assign w_rem_fix  = r_neg_r ? -w_rem_nxt  : w_rem_nxt;

  assign w_last = r_run && (r_cnt == CNT_LAST);
  assign o_done = w_last;

  always_comb begin
    o_result = '0;
    case (r_op)
      OP_MUL:                       o_result = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              o_result = w_quo_fix;
      OP_REM, OP_REMU:              o_result = w_rem_fix;
      default:                      o_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_m  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_op     <= i_op;
      r_neg_m  <= w_sa ^ w_sb;
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
      r_prod   <= '0;
      r_mplier <= w_mag_b;
      r_rem    <= '0;
      r_quo    <= w_mag_a;
      r_dvsr   <= w_mag_b;
    end else if (r_run) begin
      r_cnt    <= r_cnt + 1'b1;
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      if (w_last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - sequential ALU with valid/ready handshake and iterative M ops
// Purpose: base integer ops in one cycle, MUL/DIV/REM through ula_muldiv_iter.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with A, B, ALU_operacao;
//        out_valid/out_ready with registered result and flags zero, less,
//        less_unsigned; busy is high whenever the FSM is not idle.
module ula_seq
  import ula_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALU_operacao,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less,
  output logic            less_unsigned,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_less;
  logic            r_less_u;

  logic            w_accept;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic            w_start;
  logic            w_lt;
  logic            w_ltu;
  logic [SHW-1:0]  w_sh;
  logic [XLEN-1:0] w_fast_res;
  logic            w_iter_done;
  logic [XLEN-1:0] w_iter_res;

  assign in_ready      = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign out_valid     = (r_state == ST_DONE);
  assign result        = r_result;
  assign zero          = r_zero;
  assign less          = r_less;
  assign less_unsigned = r_less_u;

  assign w_accept  = in_valid && in_ready;
  assign w_b_zero  = (B == '0);
  assign w_ovf     = ((ALU_operacao == OP_DIV) || (ALU_operacao == OP_REM)) &&
                     (A == MOST_NEG) && (B == '1);
  assign w_special = is_div(ALU_operacao) && (w_b_zero || w_ovf);
  assign w_start   = w_accept && is_muldiv(ALU_operacao) && !w_special;
  assign w_lt      = $signed(A) < $signed(B);
  assign w_ltu     = A < B;
  assign w_sh      = B[SHW-1:0];

  // Single-cycle results; divide rows only matter for the special cases,
  // where B==0 gives all-ones/A and overflow gives A/0.
  always_comb begin
    w_fast_res = '0;
    case (ALU_operacao)
      OP_ADD:          w_fast_res = A + B;
      OP_SUB:          w_fast_res = A - B;
      OP_AND:          w_fast_res = A & B;
      OP_OR:           w_fast_res = A | B;
      OP_XOR:          w_fast_res = A ^ B;
      OP_SLL:          w_fast_res = A << w_sh;
      OP_SRL:          w_fast_res = A >> w_sh;
      OP_SRA:          w_fast_res = $signed(A) >>> w_sh;
      OP_SLT:          w_fast_res = {{(XLEN-1){1'b0}}, w_lt};
      OP_SLTU:         w_fast_res = {{(XLEN-1){1'b0}}, w_ltu};
      OP_DIV, OP_DIVU: w_fast_res = w_b_zero ? '1 : A;
      OP_REM, OP_REMU: w_fast_res = w_b_zero ? A : '0;
      default:         w_fast_res = '0;
    endcase
  end

  ula_muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_op     (ALU_operacao),
    .i_a      (A),
    .i_b      (B),
    .o_done   (w_iter_done),
    .o_result (w_iter_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_start ? ST_CALC : ST_DONE;
      ST_CALC: if (w_iter_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_less   <= 1'b0;
      r_less_u <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_less   <= w_lt;
        r_less_u <= w_ltu;
      end
      if (w_accept && !w_start) begin
        r_result <= w_fast_res;
        r_zero   <= (w_fast_res == '0);
      end else if ((r_state == ST_CALC) && w_iter_done) begin
        r_result <= w_iter_res;
        r_zero   <= (w_iter_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - directed scoreboard bench for ula_seq (XLEN=32)
module tb_ula_seq;
  import ula_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [4:0]      alu_op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            less;
  logic            less_unsigned;
  logic            busy;

  always #5 clk = ~clk;

  ula_seq #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .A             (a_i),
    .B             (b_i),
    .ALU_operacao  (alu_op),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .less          (less),
    .less_unsigned (less_unsigned),
    .busy          (busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        lt;
    logic        ltu;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check1(input string tag, input logic act, input logic exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  // Drives one op, pushes its expectation, then waits (bounded) for out_valid
  // and compares against the popped entry. hold>0 stalls the consumer.
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    int   w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check1({tag, " in_ready_before"}, in_ready, 1'b1);
    e.res = exp_res;
    e.lt  = $signed(a) < $signed(b);
    e.ltu = a < b;
    e.lat = exp_lat;
    sb_q.push_back(e);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a_i       = a;
    b_i       = b;
    alu_op    = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check1({tag, " in_ready_after_accept"}, in_ready, 1'b0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = sb_q.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(got.lat));
    check({tag, " result"}, result, got.res);
    check1({tag, " zero"}, zero, (got.res == 32'd0));
    check1({tag, " less"}, less, got.lt);
    check1({tag, " less_unsigned"}, less_unsigned, got.ltu);
    if (hold > 0) begin
      in_valid = 1'b1;
      a_i      = 32'd1;
      b_i      = 32'd1;
      alu_op   = OP_ADD;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check1({tag, " hold out_valid"}, out_valid, 1'b1);
        check({tag, " hold result"}, result, got.res);
        check1({tag, " hold zero"}, zero, (got.res == 32'd0));
        check1({tag, " hold in_ready"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check1({tag, " release in_ready"}, in_ready, 1'b1);
      check1({tag, " release out_valid"}, out_valid, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check1({tag, " release busy"}, busy, 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_i       = '0;
    b_i       = '0;
    alu_op    = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    check1("reset in_ready", in_ready, 1'b1);
    check1("reset out_valid", out_valid, 1'b0);
    check1("reset busy", busy, 1'b0);
    check("reset result", result, 32'd0);
    check1("reset zero", zero, 1'b0);
    check1("reset less", less, 1'b0);
    check1("reset less_unsigned", less_unsigned, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("ADD",    OP_ADD,    32'd5,        32'd7,        32'd12,       1, 0);
    issue("AND",    OP_AND,    32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, 0);
    issue("OR",     OP_OR,     32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1, 0);
    issue("XOR",    OP_XOR,    32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1, 0);
    issue("SLL",    OP_SLL,    32'd1,        32'h0000003F, 32'h80000000, 1, 0);
    issue("SRL",    OP_SRL,    32'h80000000, 32'd4,        32'h08000000, 1, 0);
    issue("SRA",    OP_SRA,    32'h80000000, 32'd4,        32'hF8000000, 1, 0);
    issue("SLT",    OP_SLT,    32'hFFFFFFFF, 32'd2,        32'd1,        1, 0);
    issue("SLTU0",  OP_SLTU,   32'hFFFFFFFF, 32'd2,        32'd0,        1, 0);
    issue("UNDEF",  5'h1F,     32'd9,        32'd3,        32'd0,        1, 0);

    issue("MUL",    OP_MUL,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 33, 0);
    issue("MULHU",  OP_MULHU,  32'hFFFFFFFF, 32'd2,        32'h00000001, 33, 0);
    issue("MULH",   OP_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);
    issue("MULHSU", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);
    issue("MULneg", OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33, 0);
    issue("MULlo0", OP_MUL,    32'h00010000, 32'h00010000, 32'd0,        33, 0);
    issue("MULHU2", OP_MULHU,  32'h80000000, 32'd4,        32'd2,        33, 0);

    issue("DIV",    OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    issue("REM",    OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    issue("DIVnb",  OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
    issue("REMnb",  OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33, 0);
    issue("DIVU",   OP_DIVU,   32'd7,        32'd2,        32'd3,        33, 0);
    issue("REMU",   OP_REMU,   32'd7,        32'd2,        32'd1,        33, 0);
    issue("DIVU2",  OP_DIVU,   32'd100,      32'd7,        32'd14,       33, 0);

    issue("DIV/0",  OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    issue("REMU/0", OP_REMU,   32'd5,        32'd0,        32'd5,        1, 0);
    issue("DIVovf", OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    issue("REMovf", OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    issue("SUBhold", OP_SUB,   32'd3,        32'd3,        32'd0,        1, 5);

    // Abort an in-flight multiply with reset.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_i       = 32'h12345678;
    b_i       = 32'h00000003;
    alu_op    = OP_MUL;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check1("mid-MUL busy", busy, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check1("abort out_valid", out_valid, 1'b0);
    check1("abort in_ready", in_ready, 1'b1);
    check1("abort busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check1("abort no stray out_valid", out_valid, 1'b0);

    issue("SLTU", OP_SLTU, 32'd1, 32'd2, 32'd1, 1, 0);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
